// File: rtl/interrupt_vector_sequencer.sv
// 6502 RESET/NMI/IRQ/BRK entry sequencer: stacks PCH/PCL/P, fetches the vector, strobes the PC load.
// Latency: start decision in IDLE, then PUSH_H..VEC_H over 5 enabled cycles; pc_load asserts in the 6th (LOAD).
// Backpressure: every state and register holds while clk_ph2_enable=0; consumers gate strobes with the enable.
module interrupt_vector_sequencer #(
  parameter logic [15:0] VEC_NMI = 16'hFFFA,
  parameter logic [15:0] VEC_RES = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic        clk_ph2_enable,
  input  logic        instr_boundary,
  input  logic        brk_req,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic [7:0]  PCL_in,
  input  logic [7:0]  PCH_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic [15:0] addr_out,
  output logic [7:0]  data_out,
  output logic        rw_out,
  output logic        busy,
  output logic        sp_dec,
  output logic        set_i,
  output logic [7:0]  ADL_out,
  output logic [7:0]  ADH_out,
  output logic        pc_load
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUSH_H = 3'd1,
    S_PUSH_L = 3'd2,
    S_PUSH_P = 3'd3,
    S_VEC_L  = 3'd4,
    S_VEC_H  = 3'd5,
    S_LOAD   = 3'd6
  } state_t;

  // Which entry is being serviced; selects the vector, the B bit and read-vs-write pushes.
  typedef enum logic [1:0] {
    K_RES = 2'd0,
    K_NMI = 2'd1,
    K_IRQ = 2'd2,
    K_BRK = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        res_pending_q, res_pending_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic [7:0]  vlow_q, vlow_d;
  logic [7:0]  vhigh_q, vhigh_d;

  logic        nmi_edge;
  logic [15:0] vec_addr;
  logic [7:0]  pushed_p;

  // A falling NMI edge is only recognised across two enabled samples of the line.
  assign nmi_edge = nmi_prev_q & ~nmi_n;

  // Vector selection follows the latched kind, so an NMI hijack redirects the fetch.
  always_comb begin
    vec_addr = VEC_IRQ;
    case (kind_q)
      K_RES:   vec_addr = VEC_RES;
      K_NMI:   vec_addr = VEC_NMI;
      default: vec_addr = VEC_IRQ;
    endcase
  end

  // Stacked status: bit5 always set, B set only for a software BRK entry.
  assign pushed_p = {p_in[7:6], 1'b1, (kind_q == K_BRK), p_in[3:0]};

  // Next-state, start arbitration, pending-flag bookkeeping and vector capture.
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    res_pending_d = res_pending_q;
    nmi_pending_d = nmi_pending_q;
    nmi_prev_d    = nmi_prev_q;
    vlow_d        = vlow_q;
    vhigh_d       = vhigh_q;

    if (clk_ph2_enable) begin
      nmi_prev_d = nmi_n;
      if (nmi_edge) begin
        nmi_pending_d = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // RESET does not wait for an instruction boundary; the rest do.
          if (res_pending_q) begin
            state_d = S_PUSH_H;
            kind_d  = K_RES;
          end else if (instr_boundary) begin
            if (nmi_pending_q) begin
              state_d = S_PUSH_H;
              kind_d  = K_NMI;
            end else if (brk_req) begin
              state_d = S_PUSH_H;
              kind_d  = K_BRK;
            end else if (!irq_n && !i_flag) begin
              state_d = S_PUSH_H;
              kind_d  = K_IRQ;
            end
          end
        end
        S_PUSH_H: state_d = S_PUSH_L;
        S_PUSH_L: state_d = S_PUSH_P;
        S_PUSH_P: begin
          state_d = S_VEC_L;
          // Late NMI takes over an IRQ/BRK entry; the already-stacked B bit stays as is.
          if (((kind_q == K_IRQ) || (kind_q == K_BRK)) && (nmi_pending_q || nmi_edge)) begin
            kind_d = K_NMI;
          end
          // Entering the vector fetch for an NMI consumes the pending edge.
          if (kind_d == K_NMI) begin
            nmi_pending_d = 1'b0;
          end
        end
        S_VEC_L: begin
          vlow_d  = data_in;
          state_d = S_VEC_H;
          if (kind_q == K_RES) begin
            res_pending_d = 1'b0;
          end
        end
        S_VEC_H: begin
          vhigh_d = data_in;
          state_d = S_LOAD;
        end
        S_LOAD:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset forces a pending RESET entry and drops any sequence in flight.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kind_q        <= K_RES;
      res_pending_q <= 1'b1;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b1;
      vlow_q        <= 8'h00;
      vhigh_q       <= 8'h00;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      res_pending_q <= res_pending_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_prev_q    <= nmi_prev_d;
      vlow_q        <= vlow_d;
      vhigh_q       <= vhigh_d;
    end
  end

  // Bus and strobe outputs decoded from the registered state; IDLE leaves the bus in a quiet read.
  always_comb begin
    addr_out = 16'h0000;
    data_out = 8'h00;
    rw_out   = 1'b1;
    busy     = 1'b0;
    sp_dec   = 1'b0;
    set_i    = 1'b0;
    ADL_out  = 8'h00;
    ADH_out  = 8'h00;
    pc_load  = 1'b0;

    case (state_q)
      S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
        busy     = 1'b1;
        sp_dec   = 1'b1;
        addr_out = {8'h01, sp_in};
        // RESET walks the stack with reads so nothing in page 1 is disturbed.
        rw_out   = (kind_q == K_RES);
        if (state_q == S_PUSH_H) begin
          data_out = PCH_in;
        end else if (state_q == S_PUSH_L) begin
          data_out = PCL_in;
        end else begin
          data_out = pushed_p;
        end
      end
      S_VEC_L: begin
        busy     = 1'b1;
        set_i    = 1'b1;
        addr_out = vec_addr;
      end
      S_VEC_H: begin
        busy     = 1'b1;
        addr_out = vec_addr + 16'd1;
      end
      S_LOAD: begin
        busy    = 1'b1;
        pc_load = 1'b1;
        ADL_out = vlow_q;
        ADH_out = vhigh_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_vector_sequencer.sv
// Scoreboard bench for the interrupt entry sequencer.
// Stimulus pushes the expected bus transactions per entry; a monitor pops them on each enabled busy cycle.
// The bench plays the CPU around the block: it tracks SP decrements and serves vector bytes from a small memory.
module tb_interrupt_vector_sequencer;

  localparam int KR = 0;
  localparam int KN = 1;
  localparam int KI = 2;
  localparam int KB = 3;

  logic        sys_clock = 1'b0;
  logic        reset;
  logic        clk_ph2_enable;
  logic        instr_boundary;
  logic        brk_req;
  logic        nmi_n;
  logic        irq_n;
  logic        i_flag;
  logic [7:0]  PCL_in;
  logic [7:0]  PCH_in;
  logic [7:0]  p_in;
  logic [7:0]  sp_in;
  logic [7:0]  data_in;
  logic [15:0] addr_out;
  logic [7:0]  data_out;
  logic        rw_out;
  logic        busy;
  logic        sp_dec;
  logic        set_i;
  logic [7:0]  ADL_out;
  logic [7:0]  ADH_out;
  logic        pc_load;

  always #5 sys_clock = ~sys_clock;

  interrupt_vector_sequencer dut (
    .sys_clock      (sys_clock),
    .reset          (reset),
    .clk_ph2_enable (clk_ph2_enable),
    .instr_boundary (instr_boundary),
    .brk_req        (brk_req),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .i_flag         (i_flag),
    .PCL_in         (PCL_in),
    .PCH_in         (PCH_in),
    .p_in           (p_in),
    .sp_in          (sp_in),
    .data_in        (data_in),
    .addr_out       (addr_out),
    .data_out       (data_out),
    .rw_out         (rw_out),
    .busy           (busy),
    .sp_dec         (sp_dec),
    .set_i          (set_i),
    .ADL_out        (ADL_out),
    .ADH_out        (ADH_out),
    .pc_load        (pc_load)
  );

  // Vector memory FFFA..FFFF; other addresses return a recognisable junk pattern.
  logic [7:0] vec_mem [0:5];

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a >= 16'hFFFA) return vec_mem[int'(a) - 65530];
    return a[7:0] ^ 8'h5A;
  endfunction

  always_comb data_in = mem_byte(addr_out);

  typedef struct packed {
    logic        is_load;
    logic        rw;
    logic        sp_dec;
    logic        set_i;
    logic [15:0] addr;
    logic [7:0]  dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  bit   stall_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic ld, input logic rw, input logic dec, input logic si,
                              input logic [15:0] a, input logic [7:0] d);
    exp_t x;
    x.is_load = ld;
    x.rw      = rw;
    x.sp_dec  = dec;
    x.set_i   = si;
    x.addr    = a;
    x.dat     = d;
    return x;
  endfunction

  // Reference model: what an entry of a given kind must do on the bus, from the architectural rules.
  task automatic expect_seq(input int kind, input int vkind, input logic [15:0] pc,
                            input logic [7:0] p, input logic [7:0] sp);
    logic [15:0] va;
    logic [7:0]  pp;
    logic        rd;
    logic [7:0]  s1;
    logic [7:0]  s2;
    va = (vkind == KN) ? 16'hFFFA : (vkind == KR) ? 16'hFFFC : 16'hFFFE;
    pp = (p | 8'h20) & 8'hEF;
    if (kind == KB) pp = pp | 8'h10;
    rd = (kind == KR);
    s1 = sp - 8'd1;
    s2 = sp - 8'd2;
    exp_q.push_back(mk(1'b0, rd, 1'b1, 1'b0, {8'h01, sp}, pc[15:8]));
    exp_q.push_back(mk(1'b0, rd, 1'b1, 1'b0, {8'h01, s1}, pc[7:0]));
    exp_q.push_back(mk(1'b0, rd, 1'b1, 1'b0, {8'h01, s2}, pp));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, va, 8'h00));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, va + 16'd1, 8'h00));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, {mem_byte(va + 16'd1), mem_byte(va)}, 8'h00));
  endtask

  // Monitor: every enabled cycle either matches the next expected transaction or must be idle.
  always @(negedge sys_clock) begin
    if (!reset && clk_ph2_enable) begin
      if (exp_q.size() == 0) begin
        chk("idle_busy", busy, 0);
      end else if (busy) begin
        e = exp_q.pop_front();
        chk("pc_load", pc_load, e.is_load);
        chk("sp_dec", sp_dec, e.sp_dec);
        chk("set_i", set_i, e.set_i);
        if (e.is_load) begin
          chk("new_pc", {ADH_out, ADL_out}, e.addr);
        end else begin
          chk("rw", rw_out, e.rw);
          chk("addr", addr_out, e.addr);
          if (!e.rw) chk("wdata", data_out, e.dat);
        end
      end
    end
  end

  // One clock; the bench's SP follows the sp_dec strobe like the real register would.
  task automatic cycle(input bit en);
    bit dec;
    clk_ph2_enable = en;
    @(negedge sys_clock);
    dec = en && sp_dec;
    @(posedge sys_clock);
    #1;
    if (dec) sp_in = sp_in - 8'd1;
  endtask

  task automatic en_cycle();
    if (stall_on) repeat ($urandom_range(0, 2)) cycle(1'b0);
    cycle(1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      en_cycle();
      n++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    en_cycle();
  endtask

  task automatic set_pc(input logic [15:0] v);
    PCH_in = v[15:8];
    PCL_in = v[7:0];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clk_ph2_enable = 1'b0; instr_boundary = 1'b0; brk_req = 1'b0;
    nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
    set_pc(16'h0000); p_in = 8'h00; sp_in = 8'h00;
    for (int k = 0; k < 6; k++) vec_mem[k] = 8'h00;
    vec_mem[2] = 8'h34; vec_mem[3] = 8'h12;

    // Reset state, then the power-on RESET sequence with dummy stack reads.
    repeat (2) cycle(1'b1);
    chk("rst_busy", busy, 0);
    chk("rst_rw", rw_out, 1);
    chk("rst_addr", addr_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_sp_dec", sp_dec, 0);
    chk("rst_set_i", set_i, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_adl", ADL_out, 0);
    chk("rst_adh", ADH_out, 0);
    expect_seq(KR, KR, 16'h0000, p_in, sp_in);
    reset = 1'b0;
    drain("reset_seq");
    stall_on = 1'b1;

    // Plain IRQ; the line is released right after the start.
    set_pc(16'hC123); p_in = 8'h81; sp_in = 8'hFD; i_flag = 1'b0;
    vec_mem[4] = 8'h00; vec_mem[5] = 8'h80;
    expect_seq(KI, KI, 16'hC123, 8'h81, 8'hFD);
    irq_n = 1'b0; instr_boundary = 1'b1;
    en_cycle();
    irq_n = 1'b1; instr_boundary = 1'b0;
    drain("irq");

    // Masked IRQ never starts.
    i_flag = 1'b1; irq_n = 1'b0;
    repeat (8) begin
      instr_boundary = 1'b1; en_cycle();
      instr_boundary = 1'b0; en_cycle();
    end
    chk("masked_busy", busy, 0);
    irq_n = 1'b1;

    // BRK and IRQ together: BRK wins, IRQ follows at the next boundary.
    i_flag = 1'b0; irq_n = 1'b0; set_pc(16'h4567); p_in = 8'h02; sp_in = 8'hF0;
    expect_seq(KB, KB, 16'h4567, 8'h02, 8'hF0);
    brk_req = 1'b1; instr_boundary = 1'b1;
    en_cycle();
    brk_req = 1'b0; instr_boundary = 1'b0;
    drain("brk_irq");
    set_pc(16'h8000);
    expect_seq(KI, KI, 16'h8000, 8'h02, sp_in);
    instr_boundary = 1'b1;
    en_cycle();
    instr_boundary = 1'b0; irq_n = 1'b1;
    drain("irq_after_brk");

    // BRK hijacked by an NMI edge during PUSH_L.
    set_pc(16'hE0F0); p_in = 8'h00; sp_in = 8'hFF;
    vec_mem[0] = 8'hCD; vec_mem[1] = 8'hAB;
    expect_seq(KB, KN, 16'hE0F0, 8'h00, 8'hFF);
    brk_req = 1'b1; instr_boundary = 1'b1;
    en_cycle();
    brk_req = 1'b0; instr_boundary = 1'b0;
    en_cycle();
    nmi_n = 1'b0;
    en_cycle();
    drain("brk_hijack");
    nmi_n = 1'b1;
    en_cycle();

    // NMI held low: exactly one entry; a fresh edge gives another.
    set_pc(16'h1111); p_in = 8'hC3; sp_in = 8'h80;
    expect_seq(KN, KN, 16'h1111, 8'hC3, 8'h80);
    nmi_n = 1'b0; instr_boundary = 1'b1;
    repeat (20) en_cycle();
    chk("nmi_once", exp_q.size(), 0);
    nmi_n = 1'b1;
    repeat (3) en_cycle();
    expect_seq(KN, KN, 16'h1111, 8'hC3, sp_in);
    nmi_n = 1'b0;
    drain("nmi_second");
    instr_boundary = 1'b0; nmi_n = 1'b1;
    en_cycle();

    // Randomised entries with random stalls.
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 3);
      set_pc(16'($urandom)); p_in = 8'($urandom); sp_in = 8'($urandom);
      for (int k = 0; k < 6; k++) vec_mem[k] = 8'($urandom);
      case (sel)
        0: begin
          i_flag = 1'($urandom);
          if (!i_flag) expect_seq(KI, KI, {PCH_in, PCL_in}, p_in, sp_in);
          irq_n = 1'b0; instr_boundary = 1'b1;
          en_cycle();
          irq_n = 1'b1; instr_boundary = 1'b0;
          repeat (2) en_cycle();
        end
        1: begin
          i_flag = 1'($urandom); irq_n = 1'($urandom);
          expect_seq(KB, KB, {PCH_in, PCL_in}, p_in, sp_in);
          brk_req = 1'b1; instr_boundary = 1'b1;
          en_cycle();
          brk_req = 1'b0; instr_boundary = 1'b0; irq_n = 1'b1;
        end
        2: begin
          expect_seq(KN, KN, {PCH_in, PCL_in}, p_in, sp_in);
          nmi_n = 1'b0; instr_boundary = 1'b1;
          en_cycle();
          en_cycle();
          instr_boundary = 1'b0; nmi_n = 1'b1;
        end
        default: begin
          expect_seq(KB, KN, {PCH_in, PCL_in}, p_in, sp_in);
          brk_req = 1'b1; instr_boundary = 1'b1;
          en_cycle();
          brk_req = 1'b0; instr_boundary = 1'b0;
          en_cycle();
          nmi_n = 1'b0;
          en_cycle();
        end
      endcase
      drain("random");
      nmi_n = 1'b1;
      en_cycle();
    end

    // Reset during VEC_H: sequence abandoned, full RESET entry follows.
    set_pc(16'h2468); p_in = 8'h00; sp_in = 8'hA0; i_flag = 1'b0;
    vec_mem[2] = 8'h78; vec_mem[3] = 8'h56;
    expect_seq(KI, KI, 16'h2468, 8'h00, 8'hA0);
    irq_n = 1'b0; instr_boundary = 1'b1;
    en_cycle();
    irq_n = 1'b1; instr_boundary = 1'b0;
    repeat (4) en_cycle();
    chk("reached_vec_h", addr_out, 16'hFFFF);
    reset = 1'b1;
    cycle(1'b0);
    exp_q.delete();
    chk("busy_after_reset", busy, 0);
    chk("rw_after_reset", rw_out, 1);
    cycle(1'b1);
    expect_seq(KR, KR, {PCH_in, PCL_in}, p_in, sp_in);
    reset = 1'b0;
    drain("reset_mid");
    repeat (4) en_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
